// File: rtl/rst_sync_seq.sv
// rst_sync_seq: async-assert / sync-release reset synchroniser that stretches reset
// and then releases NUM_CH downstream domains in order, CH_GAP edges apart.
module rst_sync_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 3,
  parameter int STRETCH     = 4,
  parameter int CH_GAP      = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
);
  localparam int SCW = STRETCH > 1 ? $clog2(STRETCH) : 1;
  localparam int GCW = CH_GAP > 1 ? $clog2(CH_GAP) : 1;
  typedef enum logic [1:0] {S_HOLD, S_STRETCH, S_RELEASE, S_DONE} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SCW-1:0]         st_cnt_q, st_cnt_d;
  logic [GCW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [NUM_CH-1:0]      rel_q, rel_d;
  // Channels release strictly in order, so the released set is a run of ones shifted in from bit 0.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d   = state_q;
    st_cnt_d  = st_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rel_d     = rel_q;
    if (state_q == S_HOLD) begin
      if (sync_q[SYNC_STAGES-1]) begin
        state_d  = S_STRETCH;
        st_cnt_d = '0;
      end
    end else if (SW_RST_REQ) begin
      state_d   = S_STRETCH;
      st_cnt_d  = '0;
      gap_cnt_d = '0;
      rel_d     = '0;
    end else if (state_q == S_STRETCH) begin
      if (st_cnt_q == SCW'(STRETCH - 1)) begin
        rel_d     = NUM_CH'(1);
        gap_cnt_d = '0;
        state_d   = (NUM_CH == 1) ? S_DONE : S_RELEASE;
      end else begin
        st_cnt_d = st_cnt_q + 1'b1;
      end
    end else if (state_q == S_RELEASE) begin
      if (gap_cnt_q == GCW'(CH_GAP - 1)) begin
        rel_d     = NUM_CH'({rel_q, 1'b1});
        gap_cnt_d = '0;
        state_d   = (&rel_d) ? S_DONE : S_RELEASE;
      end else begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_HOLD;
      sync_q    <= '0;
      st_cnt_q  <= '0;
      gap_cnt_q <= '0;
      rel_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      st_cnt_q  <= st_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rel_q     <= rel_d;
    end
  end
  assign SYNC_RST = rel_q;
  assign RST_DONE = &rel_q;
endmodule

// File: tb/tb_rst_sync_seq.sv
// tb_rst_sync_seq: scoreboard bench; expected output transitions are queued from
// release-time arithmetic and popped by a monitor whenever the DUT outputs change.
module tb_rst_sync_seq;
  localparam int S = 2, N = 3, ST = 4, G = 2;
  typedef struct {int c; logic [N:0] v;} ev_t;
  logic clk = 1'b0;
  logic rst, sw, rst1, sw1;
  logic [N-1:0] sync_rst;
  logic rst_done;
  logic [0:0] sync_rst1;
  logic rst_done1;
  int checks = 0, errors = 0, cyc = 0;
  int entry = 1 << 30;
  ev_t sbq[$];
  logic [N:0] exp_cur = '0, prev = '0;

  rst_sync_seq #(.SYNC_STAGES(S), .NUM_CH(N), .STRETCH(ST), .CH_GAP(G)) u_dut (
    .CLK(clk), .RST(rst), .SW_RST_REQ(sw), .SYNC_RST(sync_rst), .RST_DONE(rst_done));
  rst_sync_seq #(.SYNC_STAGES(3), .NUM_CH(1), .STRETCH(1), .CH_GAP(1)) u_dut1 (
    .CLK(clk), .RST(rst1), .SW_RST_REQ(sw1), .SYNC_RST(sync_rst1), .RST_DONE(rst_done1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [N:0] cur;
    ev_t e;
    cur = {rst_done, sync_rst};
    if (cur !== prev) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc %0d: got %b, no change expected (held %b)", cyc, cur, prev);
      end else begin
        e = sbq.pop_front();
        if (e.v !== cur || e.c != cyc) begin
          errors++;
          $display("FAIL transition cyc %0d: got %b, want %b at cyc %0d", cyc, cur, e.v, e.c);
        end
        exp_cur = e.v;
      end
      prev = cur;
    end else if (sbq.size() > 0 && sbq[0].c <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_transition cyc %0d: got %b, want %b at cyc %0d", cyc, cur, sbq[0].v, sbq[0].c);
      exp_cur = sbq[0].v;
      void'(sbq.pop_front());
    end
  end

  task automatic chk(string name, logic [N:0] got, logic [N:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_rel(int r0);
    ev_t e;
    for (int i = 0; i < N; i++) begin
      e.c = r0 + i * G;
      e.v = '0;
      for (int j = 0; j <= i; j++) e.v[j] = 1'b1;
      e.v[N] = (i == N - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic rst_assert();
    ev_t e;
    rst = 1'b1;
    sbq.delete();
    entry = 1 << 30;
    if (exp_cur != '0) begin
      e.c = cyc + 1;
      e.v = '0;
      sbq.push_back(e);
    end
    #1;
    chk("async_assert", {rst_done, sync_rst}, '0);
  endtask

  task automatic rst_fall();
    rst = 1'b0;
    entry = cyc + S + 1;
    push_rel(entry + ST);
  endtask

  task automatic sw_cycles(int n);
    ev_t e;
    sw = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (cyc + 1 > entry) begin
        sbq.delete();
        if (exp_cur != '0) begin
          e.c = cyc + 1;
          e.v = '0;
          sbq.push_back(e);
        end
        push_rel(cyc + 1 + ST);
      end
      step();
    end
    sw = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = 1'b0; rst1 = 1'b1; sw1 = 1'b0;
    step();
    chk("reset_state", {rst_done, sync_rst}, '0);
    chk("reset_state_sweep", (N+1)'({rst_done1, sync_rst1}), '0);
    repeat (2) step();
    rst_fall();
    repeat (14) step();
    rst_assert();
    repeat (2) step();
    rst_fall();
    repeat (14) step();
    sw_cycles(1);
    repeat (10) step();
    sw_cycles(1);
    repeat (4) step();
    sw_cycles(1);
    repeat (12) step();
    sw_cycles(1);
    repeat (2) step();
    rst_assert();
    rst_fall();
    repeat (14) step();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(1, 15)) step();
        1: sw_cycles(1);
        2: sw_cycles($urandom_range(2, 6));
        default: begin
          rst_assert();
          if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) step();
          rst_fall();
          if ($urandom_range(0, 1) == 1) sw_cycles(1);
        end
      endcase
    end
    repeat (40) step();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending transitions, want 0", sbq.size());
    end
    rst1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("sweep_release", (N+1)'({rst_done1, sync_rst1}), (N+1)'(k >= 5 ? 3 : 0));
    end
    sw1 = 1'b1;
    repeat (5) begin
      step();
      chk("sweep_sw_hold", (N+1)'({rst_done1, sync_rst1}), '0);
    end
    sw1 = 1'b0;
    step();
    chk("sweep_sw_drop", (N+1)'({rst_done1, sync_rst1}), (N+1)'(3));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
